// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the frame dispatcher in front of the 1x4 demux.
//   state_t : dispatcher FSM states (IDLE / XFER / DONE)
//   NCH     : number of downstream channels
//   CH_W    : width of a channel select
package demux_dispatch_pkg;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CH_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/demux_sat_cnt.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
//   clk, rst : clock, synchronous active-high reset (clears count)
//   inc      : increment enable
//   cnt      : current count
module demux_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Frame-level dispatcher feeding the 1x4 case-statement demux. Takes a header
// (destination channel + payload length), then passes that many payload bits
// through with sel frozen for the whole frame, honouring only the ready bit of
// the selected channel. frame_done pulses for one cycle after the last bit.
//
// Optional feature macro: DISPATCH_STATS_EN adds per-channel saturating
// completed-frame counters on frame_cnt (channel 0 in the LSBs).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   hdr_valid/hdr_ready           header handshake; hdr_dest, hdr_len payload
//   bit_valid/bit_ready, bit_in   upstream payload bit stream
//   sel, out_valid, out_bit       to downstream demux
//   out_ready[3:0]                per-channel downstream ready
//   busy                          high whenever not IDLE
//   frame_done                    one-cycle end-of-frame pulse
//   frame_cnt                     per-channel frame counts (DISPATCH_STATS_EN only)
module demux_dispatch_ctrl
  import demux_dispatch_pkg::*;
#(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hdr_valid,
  output logic                 hdr_ready,
  input  logic [CH_W-1:0]      hdr_dest,
  input  logic [LEN_W-1:0]     hdr_len,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  input  logic                 bit_in,
  output logic [CH_W-1:0]      sel,
  output logic                 out_valid,
  output logic                 out_bit,
  input  logic [NCH-1:0]       out_ready,
  output logic                 busy,
  output logic                 frame_done
`ifdef DISPATCH_STATS_EN
  ,
  output logic [NCH*CNT_W-1:0] frame_cnt
`endif
);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             in_xfer;
  logic             xfer;

  assign in_xfer = (state == XFER);
  // Only the selected channel's ready gates the transfer.
  assign xfer    = in_xfer && bit_valid && out_ready[sel];

  // Frame sequencing: header capture, bit countdown, one-cycle completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hdr_valid) begin
            sel       <= hdr_dest;
            remaining <= hdr_len;
            state     <= (hdr_len != '0) ? XFER : DONE;
          end
        end
        XFER: begin
          if (xfer) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status decoded straight from the state register; payload path is a
  // zero-latency pass-through gated to XFER.
  assign hdr_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign out_valid  = in_xfer && bit_valid;
  assign out_bit    = in_xfer && bit_in;
  assign bit_ready  = in_xfer && out_ready[sel];

`ifdef DISPATCH_STATS_EN
  // Each channel counts frames completed on it, zero-length frames included.
  for (genvar i = 0; i < NCH; i++) begin : g_cnt
    demux_sat_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(frame_done && (sel == CH_W'(i))),
      .cnt(frame_cnt[i*CNT_W +: CNT_W])
    );
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: table-driven frames, hand-built
// stall / zero-length / reset / saturation sequences and random frames, all
// judged against frame-level expectations (payload streams per channel,
// completion timing, completed-frame tallies).
module tb_demux_dispatch_ctrl;

  localparam int unsigned LEN_W = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             hdr_valid;
  logic             hdr_ready;
  logic [1:0]       hdr_dest;
  logic [LEN_W-1:0] hdr_len;
  logic             bit_valid;
  logic             bit_ready;
  logic             bit_in;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_bit;
  logic [3:0]       out_ready;
  logic             busy;
  logic             frame_done;
  logic [4*CNT_W-1:0] frame_cnt;

  demux_dispatch_ctrl #(
    .LEN_W(LEN_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hdr_valid (hdr_valid),
    .hdr_ready (hdr_ready),
    .hdr_dest  (hdr_dest),
    .hdr_len   (hdr_len),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_in    (bit_in),
    .sel       (sel),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_done(frame_done)
`ifdef DISPATCH_STATS_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

`ifndef DISPATCH_STATS_EN
  assign frame_cnt = '0;
`endif

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int frames [4];
  logic [2:0] exp_q [$];
  logic [2:0] got_q [$];

  typedef struct {
    logic [1:0]  dest;
    logic [3:0]  len;
    logic [15:0] data;
    logic [3:0]  mask;
    int          exp_done;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Observed transfers as seen by the downstream demux.
  always @(negedge clk) begin
    if (!rst && out_valid && bit_ready) got_q.push_back({sel, out_bit});
  end

  task automatic chk_counts();
`ifdef DISPATCH_STATS_EN
    for (int c = 0; c < 4; c++) begin
      logic [CNT_W-1:0] v;
      v = frame_cnt[c*CNT_W +: CNT_W];
      chk($sformatf("frame_cnt[%0d]", c), 32'(v),
          (frames[c] > int'(CMAX)) ? CMAX : 32'(frames[c]));
    end
`endif
  endtask

  // One whole frame from header to the idle cycle after frame_done.
  task automatic send_frame(input logic [1:0] dest, input logic [3:0] len,
                            input logic [15:0] data, input bit rnd,
                            input logic [3:0] mask, output int cycles);
    int sent = 0;
    int guard = 0;
    hdr_valid = 1'b1; hdr_dest = dest; hdr_len = len;
    bit_valid = 1'b0; out_ready = rnd ? 4'($urandom) : mask;
    @(negedge clk);
    chk("hdr_ready_idle", 32'(hdr_ready), 1);
    cyc();
    hdr_valid = 1'b0; hdr_dest = 2'($urandom); hdr_len = 4'($urandom);
    cycles = 1;
    while (sent < int'(len) && guard < 300) begin
      bit_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bit_in    = rnd ? 1'($urandom) : data[sent];
      out_ready = rnd ? 4'($urandom) : mask;
      hdr_valid = 1'($urandom);
      @(negedge clk);
      chk("sel_xfer", 32'(sel), 32'(dest));
      chk("out_valid", 32'(out_valid), 32'(bit_valid));
      chk("out_bit", 32'(out_bit), 32'(bit_in));
      chk("bit_ready", 32'(bit_ready), 32'(out_ready[dest]));
      chk("hdr_ready_xfer", 32'(hdr_ready), 0);
      chk("done_early", 32'(frame_done), 0);
      if (bit_valid && out_ready[dest]) begin
        exp_q.push_back({dest, bit_in});
        sent++;
      end
      cyc();
      cycles++;
      guard++;
    end
    if (guard >= 300) chk("frame_timeout", 32'(sent), 32'(len));
    hdr_valid = 1'b0;
    bit_valid = 1'b1; bit_in = 1'($urandom); out_ready = 4'hF;
    @(negedge clk);
    chk("frame_done", 32'(frame_done), 1);
    chk("busy_done", 32'(busy), 1);
    chk("out_valid_done", 32'(out_valid), 0);
    chk("bit_ready_done", 32'(bit_ready), 0);
    chk("hdr_ready_done", 32'(hdr_ready), 0);
    chk("sel_done", 32'(sel), 32'(dest));
    frames[dest]++;
    cyc();
    @(negedge clk);
    chk("done_pulse_end", 32'(frame_done), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("sel_hold", 32'(sel), 32'(dest));
    chk("out_valid_idle", 32'(out_valid), 0);
    chk_counts();
    cyc();
  endtask

  initial begin
    int cyc_n;
    tbl[0] = '{dest: 2'd2, len: 4'd3,  data: 16'h0005, mask: 4'hF, exp_done: 4};
    tbl[1] = '{dest: 2'd1, len: 4'd0,  data: 16'h0000, mask: 4'hF, exp_done: 1};
    tbl[2] = '{dest: 2'd0, len: 4'd1,  data: 16'h0001, mask: 4'h1, exp_done: 2};
    tbl[3] = '{dest: 2'd3, len: 4'd15, data: 16'h5A3C, mask: 4'h8, exp_done: 16};
    tbl[4] = '{dest: 2'd1, len: 4'd4,  data: 16'h000B, mask: 4'h2, exp_done: 5};
    tbl[5] = '{dest: 2'd0, len: 4'd7,  data: 16'h006E, mask: 4'hF, exp_done: 8};
    for (int c = 0; c < 4; c++) frames[c] = 0;

    rst = 1'b1; hdr_valid = 1'b0; hdr_dest = '0; hdr_len = '0;
    bit_valid = 1'b0; bit_in = 1'b0; out_ready = 4'hF;
    repeat (3) cyc();
    rst = 1'b0;
    bit_valid = 1'b1;
    @(negedge clk);
    chk("rst_hdr_ready", 32'(hdr_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_bit_ready", 32'(bit_ready), 0);
    chk("rst_sel", 32'(sel), 0);
    chk_counts();
    cyc();

    // Table frames.
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].dest, tbl[i].len, tbl[i].data, 1'b0, tbl[i].mask, cyc_n);
      chk($sformatf("done_cycle[%0d]", i), 32'(cyc_n), 32'(tbl[i].exp_done));
    end

    // Stall on channel 3 while other channels are ready.
    hdr_valid = 1'b1; hdr_dest = 2'd3; hdr_len = 4'd2; bit_valid = 1'b0;
    cyc();
    hdr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bit_valid = 1'b1; bit_in = 1'b1; out_ready = 4'b0111;
      @(negedge clk);
      chk("stall_bit_ready", 32'(bit_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_done", 32'(frame_done), 0);
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      bit_in = 1'(k); out_ready = 4'b1111;
      @(negedge clk);
      chk("release_bit_ready", 32'(bit_ready), 1);
      chk("release_done", 32'(frame_done), 0);
      exp_q.push_back({2'd3, 1'(k)});
      cyc();
    end
    bit_valid = 1'b0;
    @(negedge clk);
    chk("stall_frame_done", 32'(frame_done), 1);
    frames[3]++;
    cyc();
    cyc();

    // Reset after 2 of 5 bits aborts the frame.
    hdr_valid = 1'b1; hdr_dest = 2'd1; hdr_len = 4'd5;
    cyc();
    hdr_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bit_valid = 1'b1; bit_in = 1'b1; out_ready = 4'hF;
      exp_q.push_back({2'd1, 1'b1});
      cyc();
    end
    bit_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) frames[c] = 0;
    @(negedge clk);
    chk("abort_hdr_ready", 32'(hdr_ready), 1);
    chk("abort_sel", 32'(sel), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(frame_done), 0);
    chk_counts();
    cyc();
    @(negedge clk);
    chk("abort_no_done", 32'(frame_done), 0);
    cyc();

    // Saturation: five frames to channel 0.
    for (int i = 0; i < 5; i++) begin
      send_frame(2'd0, 4'(i), 16'($urandom), 1'b0, 4'h1, cyc_n);
      chk("sat_done_cycle", 32'(cyc_n), 32'(i + 1));
    end

    // Random frames.
    for (int i = 0; i < 40; i++) begin
      send_frame(2'($urandom), 4'($urandom), 16'h0, 1'b1, 4'h0, cyc_n);
    end

    chk("stream_len", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) chk($sformatf("stream[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    total++;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
